// File: rtl/skyline_vertex_decoder_pkg.sv
// Shared definitions for the skyline vertex decoder: default sizes, FSM
// encoding and the bit positions of the per-frame error causes.
package skyline_vertex_decoder_pkg;

   localparam int DW_DEF       = 6;
   localparam int MAP_W_DEF    = 31;
   localparam int MAX_VERT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   localparam int ERR_W     = 4;
   localparam int ERR_ODD   = 0;
   localparam int ERR_RANGE = 1;
   localparam int ERR_ORDER = 2;
   localparam int ERR_OVFL  = 3;

endpackage

// File: rtl/skyline_vertex_decoder_store.sv
// Vertex register file: accepts the x,h word stream, keeps only well-formed
// vertices and records why any word was rejected.
module skyline_vertex_store
   import skyline_vertex_decoder_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int MAP_W    = MAP_W_DEF,
   parameter int MAX_VERT = MAX_VERT_DEF,
   localparam int IW      = $clog2(MAX_VERT),
   localparam int VCW     = $clog2(MAX_VERT + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [DW-1:0]    wr_data,
   input  logic [IW-1:0]    rd_idx,
   output logic [VCW-1:0]   vert_cnt,
   output logic [DW-1:0]    rd_x,
   output logic [DW-1:0]    rd_x_next,
   output logic [DW-1:0]    rd_h,
   output logic [ERR_W-1:0] err
);

   localparam int WCW = $clog2(2 * MAX_VERT + 2);

   logic [DW-1:0]    xs_r [MAX_VERT];
   logic [DW-1:0]    hs_r [MAX_VERT];
   logic [WCW-1:0]   word_cnt_r;
   logic             phase_r;
   logic [VCW-1:0]   vcnt_r;
   logic             pend_r;
   logic [ERR_W-1:0] err_r;

   logic [WCW-1:0]   base_wcnt_s, nxt_wcnt_s;
   logic             base_phase_s, nxt_phase_s;
   logic [VCW-1:0]   base_vcnt_s, nxt_vcnt_s, last_idx_s;
   logic             base_pend_s, nxt_pend_s;
   logic [ERR_W-1:0] base_err_s, nxt_err_s;
   logic             range_bad_s, order_bad_s, x_we_s, h_we_s;

   // Start-of-frame words see a cleared context; otherwise continue the frame.
   always_comb begin
      if (clear) begin
         base_wcnt_s  = {WCW{1'b0}};
         base_phase_s = 1'b0;
         base_vcnt_s  = {VCW{1'b0}};
         base_pend_s  = 1'b0;
         base_err_s   = {ERR_W{1'b0}};
      end else begin
         base_wcnt_s  = word_cnt_r;
         base_phase_s = phase_r;
         base_vcnt_s  = vcnt_r;
         base_pend_s  = pend_r;
         base_err_s   = err_r;
      end
   end

   // A vertex only commits once its h arrives, so a rejected or trailing x
   // never becomes visible to the emitter.
   always_comb begin
      nxt_wcnt_s  = base_wcnt_s;
      nxt_phase_s = base_phase_s;
      nxt_vcnt_s  = base_vcnt_s;
      nxt_pend_s  = base_pend_s;
      nxt_err_s   = base_err_s;
      last_idx_s  = base_vcnt_s - VCW'(1);
      range_bad_s = (wr_data >= DW'(MAP_W));
      if (base_vcnt_s != {VCW{1'b0}}) begin
         order_bad_s = (wr_data <= xs_r[last_idx_s[IW-1:0]]);
      end else begin
         order_bad_s = 1'b0;
      end
      x_we_s = 1'b0;
      h_we_s = 1'b0;
      if (wr_en) begin
         nxt_phase_s = ~base_phase_s;
         if (base_wcnt_s >= WCW'(2 * MAX_VERT)) begin
            nxt_err_s[ERR_OVFL] = 1'b1;
         end else begin
            nxt_wcnt_s = base_wcnt_s + WCW'(1);
            if (!base_phase_s) begin
               x_we_s     = !range_bad_s && !order_bad_s;
               nxt_pend_s = !range_bad_s && !order_bad_s;
               nxt_err_s[ERR_RANGE] = base_err_s[ERR_RANGE] | range_bad_s;
               nxt_err_s[ERR_ORDER] = base_err_s[ERR_ORDER] | (order_bad_s & !range_bad_s);
            end else begin
               h_we_s     = base_pend_s;
               nxt_pend_s = 1'b0;
               if (base_pend_s) begin
                  nxt_vcnt_s = base_vcnt_s + VCW'(1);
               end else begin
                  nxt_vcnt_s = base_vcnt_s;
               end
            end
         end
      end else begin
         nxt_phase_s = base_phase_s;
      end
   end

   // Frame context and vertex storage.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         word_cnt_r <= {WCW{1'b0}};
         phase_r    <= 1'b0;
         vcnt_r     <= {VCW{1'b0}};
         pend_r     <= 1'b0;
         err_r      <= {ERR_W{1'b0}};
         for (int i = 0; i < MAX_VERT; i++) begin
            xs_r[i] <= {DW{1'b0}};
            hs_r[i] <= {DW{1'b0}};
         end
      end else begin
         if (wr_en) begin
            word_cnt_r <= nxt_wcnt_s;
            phase_r    <= nxt_phase_s;
            vcnt_r     <= nxt_vcnt_s;
            pend_r     <= nxt_pend_s;
            err_r      <= nxt_err_s;
         end
         if (x_we_s) begin
            xs_r[base_vcnt_s[IW-1:0]] <= wr_data;
         end
         if (h_we_s) begin
            hs_r[base_vcnt_s[IW-1:0]] <= wr_data;
         end
      end
   end

   // Read ports and error summary; an x still waiting for its h is the odd case.
   always_comb begin
      vert_cnt       = vcnt_r;
      rd_x           = xs_r[rd_idx];
      rd_x_next      = xs_r[rd_idx + IW'(1)];
      rd_h           = hs_r[rd_idx];
      err            = err_r;
      err[ERR_ODD]   = phase_r;
   end

endmodule

// File: rtl/skyline_vertex_decoder.sv
// Skyline vertex decoder: collects a vertex burst and replays it as one height
// per map column, flagging malformed streams.
module skyline_vertex_decoder
   import skyline_vertex_decoder_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int MAP_W    = MAP_W_DEF,
   parameter int MAX_VERT = MAX_VERT_DEF
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          IN_VALID,
   input  logic [DW-1:0] IN_DATA,
   output logic          OUT_VALID,
   output logic [DW-1:0] OUT_DATA,
   output logic          OUT_ERR,
   output logic          BUSY
);

   localparam int IW  = $clog2(MAX_VERT);
   localparam int VCW = $clog2(MAX_VERT + 1);
   localparam int CW  = $clog2(MAP_W + 1);

   state_t           state_r;
   logic [CW-1:0]    col_r;
   logic [IW-1:0]    ptr_r;
   logic             frame_err_r;

   logic             clear_s, wr_en_s, adv_s;
   logic [VCW-1:0]   vert_cnt_s;
   logic [DW-1:0]    rd_x_s, rd_x_next_s, rd_h_s, cur_h_s;
   logic [ERR_W-1:0] err_s;

   skyline_vertex_store #(
      .DW       (DW),
      .MAP_W    (MAP_W),
      .MAX_VERT (MAX_VERT)
   ) u_store (
      .CLK       (CLK),
      .RESET     (RESET),
      .clear     (clear_s),
      .wr_en     (wr_en_s),
      .wr_data   (IN_DATA),
      .rd_idx    (ptr_r),
      .vert_cnt  (vert_cnt_s),
      .rd_x      (rd_x_s),
      .rd_x_next (rd_x_next_s),
      .rd_h      (rd_h_s),
      .err       (err_s)
   );

   // Store control and the height of the current column; x is strictly
   // increasing, so the pointer only ever steps forward by one.
   always_comb begin
      clear_s = (state_r == IDLE) && IN_VALID;
      wr_en_s = IN_VALID && (state_r != EMIT);
      if ((vert_cnt_s != {VCW{1'b0}}) && (rd_x_s <= DW'(col_r))) begin
         cur_h_s = rd_h_s;
      end else begin
         cur_h_s = {DW{1'b0}};
      end
      if (((VCW'(ptr_r) + VCW'(1)) < vert_cnt_s) &&
          (rd_x_next_s == (DW'(col_r) + DW'(1)))) begin
         adv_s = 1'b1;
      end else begin
         adv_s = 1'b0;
      end
   end

   // Frame FSM with registered outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r     <= IDLE;
         col_r       <= {CW{1'b0}};
         ptr_r       <= {IW{1'b0}};
         frame_err_r <= 1'b0;
         OUT_VALID   <= 1'b0;
         OUT_DATA    <= {DW{1'b0}};
         OUT_ERR     <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               OUT_VALID <= 1'b0;
               OUT_DATA  <= {DW{1'b0}};
               OUT_ERR   <= 1'b0;
               BUSY      <= IN_VALID;
               if (IN_VALID) begin
                  state_r <= COLLECT;
               end
            end
            COLLECT: begin
               BUSY <= 1'b1;
               if (!IN_VALID) begin
                  state_r     <= EMIT;
                  col_r       <= {CW{1'b0}};
                  ptr_r       <= {IW{1'b0}};
                  frame_err_r <= |err_s;
               end
            end
            EMIT: begin
               if (col_r == CW'(MAP_W)) begin
                  state_r   <= IDLE;
                  OUT_VALID <= 1'b0;
                  OUT_DATA  <= {DW{1'b0}};
                  OUT_ERR   <= 1'b0;
                  BUSY      <= 1'b0;
               end else begin
                  OUT_VALID <= 1'b1;
                  OUT_DATA  <= cur_h_s;
                  OUT_ERR   <= frame_err_r;
                  BUSY      <= 1'b1;
                  col_r     <= col_r + CW'(1);
                  if (adv_s) begin
                     ptr_r <= ptr_r + IW'(1);
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_skyline_vertex_decoder.sv
// Self-checking bench for skyline_vertex_decoder: directed bursts, a profile
// model computed from the vertex rules, and literal spot checks.
module tb_skyline_vertex_decoder;

   localparam int MAP_W = 31;
   localparam int MAXV  = 16;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       IN_VALID = 1'b0;
   logic [5:0] IN_DATA = 6'd0;
   logic       OUT_VALID;
   logic [5:0] OUT_DATA;
   logic       OUT_ERR;
   logic       BUSY;

   int n_checks = 0;
   int n_fail   = 0;
   int wq[$];
   int exp_prof[MAP_W];
   int exp_err = 0;
   int cap[MAP_W];
   int cap_err = 0;
   int col_idx = 0;

   skyline_vertex_decoder dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .IN_VALID  (IN_VALID),
      .IN_DATA   (IN_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_DATA  (OUT_DATA),
      .OUT_ERR   (OUT_ERR),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected profile straight from the vertex rules.
   function automatic void model();
      int np;
      int x;
      int h;
      int v;
      int ax[$];
      int ah[$];
      np      = wq.size() / 2;
      exp_err = (wq.size() % 2 != 0) ? 1 : 0;
      if (np > MAXV) begin
         exp_err = 1;
         np      = MAXV;
      end
      for (int k = 0; k < np; k++) begin
         x = wq[2*k];
         h = wq[2*k+1];
         if (x >= MAP_W || (ax.size() > 0 && x <= ax[ax.size()-1])) begin
            exp_err = 1;
         end else begin
            ax.push_back(x);
            ah.push_back(h);
         end
      end
      for (int c = 0; c < MAP_W; c++) begin
         v = 0;
         for (int i = 0; i < ax.size(); i++) begin
            if (ax[i] <= c) v = ah[i];
         end
         exp_prof[c] = v;
      end
   endfunction

   // Output checker: every cycle out of reset.
   always @(negedge CLK) begin
      if (RESET) begin
         col_idx = 0;
      end else if (OUT_VALID) begin
         if (col_idx < MAP_W) begin
            chk("col_data", int'(OUT_DATA), exp_prof[col_idx]);
            chk("col_err", int'(OUT_ERR), exp_err);
            cap[col_idx] = int'(OUT_DATA);
            if (col_idx == 0) cap_err = int'(OUT_ERR);
         end else begin
            chk("frame_len_long", col_idx + 1, MAP_W);
         end
         col_idx++;
      end else begin
         chk("idle_data", int'(OUT_DATA), 0);
         chk("idle_err", int'(OUT_ERR), 0);
         if (col_idx != 0) begin
            chk("frame_len", col_idx, MAP_W);
            col_idx = 0;
         end
      end
   end

   task automatic send_burst();
      model();
      for (int i = 0; i < wq.size(); i++) begin
         @(negedge CLK);
         IN_VALID = 1'b1;
         IN_DATA  = 6'(wq[i]);
         if (i > 0) chk("busy_collect", int'(BUSY), 1);
      end
      @(negedge CLK);
      IN_VALID = 1'b0;
      IN_DATA  = 6'd0;
   endtask

   task automatic wait_done(input int pulse_at);
      int done;
      @(negedge CLK);
      chk("gap_valid", int'(OUT_VALID), 0);
      chk("gap_busy", int'(BUSY), 1);
      @(negedge CLK);
      chk("first_valid", int'(OUT_VALID), 1);
      done = 0;
      for (int i = 0; i < 40 && done == 0; i++) begin
         @(negedge CLK);
         if (pulse_at >= 0 && (i == pulse_at || i == pulse_at + 1)) begin
            IN_VALID = 1'b1;
            IN_DATA  = 6'd1;
         end else begin
            IN_VALID = 1'b0;
            IN_DATA  = 6'd0;
         end
         if (!OUT_VALID) done = 1;
      end
      chk("frame_end", done, 1);
      chk("busy_end", int'(BUSY), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge CLK);
      chk("rst_valid", int'(OUT_VALID), 0);
      chk("rst_data", int'(OUT_DATA), 0);
      chk("rst_err", int'(OUT_ERR), 0);
      chk("rst_busy", int'(BUSY), 0);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      wq = '{2, 5, 6, 3, 9, 0};
      send_burst(); wait_done(-1);
      chk("basic_c1", cap[1], 0);   chk("basic_c2", cap[2], 5);
      chk("basic_c5", cap[5], 5);   chk("basic_c6", cap[6], 3);
      chk("basic_c8", cap[8], 3);   chk("basic_c9", cap[9], 0);
      chk("basic_c30", cap[30], 0); chk("basic_err", cap_err, 0);

      wq = '{0, 7};
      send_burst(); wait_done(-1);
      chk("x0_c0", cap[0], 7); chk("x0_c30", cap[30], 7);

      wq = '{30, 4};
      send_burst(); wait_done(5);
      chk("x30_c29", cap[29], 0); chk("x30_c30", cap[30], 4);
      @(negedge CLK);
      chk("no_restart", int'(BUSY), 0);

      wq = '{3, 2, 8};
      send_burst(); wait_done(-1);
      chk("odd_c2", cap[2], 0); chk("odd_c3", cap[3], 2); chk("odd_err", cap_err, 1);

      wq = '{5, 4, 5, 9};
      send_burst(); wait_done(-1);
      chk("ord_c5", cap[5], 4); chk("ord_c30", cap[30], 4); chk("ord_err", cap_err, 1);

      wq = '{31, 6};
      send_burst(); wait_done(-1);
      chk("rng_c0", cap[0], 0); chk("rng_c30", cap[30], 0); chk("rng_err", cap_err, 1);

      wq = {};
      for (int x = 0; x <= 16; x++) begin
         wq.push_back(x);
         wq.push_back(x + 1);
      end
      send_burst(); wait_done(-1);
      chk("ovf_c0", cap[0], 1);   chk("ovf_c15", cap[15], 16);
      chk("ovf_c16", cap[16], 16); chk("ovf_err", cap_err, 1);

      // Back-to-back: second burst starts the cycle after OUT_VALID falls.
      wq = '{9, 3};
      send_burst(); wait_done(-1);
      wq = '{1, 3, 20, 1};
      send_burst(); wait_done(-1);
      chk("b2b_c0", cap[0], 0);   chk("b2b_c1", cap[1], 3);
      chk("b2b_c19", cap[19], 3); chk("b2b_c20", cap[20], 1);
      chk("b2b_err", cap_err, 0);

      // Reset in the middle of emission.
      wq = '{2, 5};
      send_burst();
      for (int i = 0; i < 10 && !OUT_VALID; i++) @(negedge CLK);
      chk("rst_mid_start", int'(OUT_VALID), 1);
      repeat (10) @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      chk("rst_mid_valid", int'(OUT_VALID), 0);
      chk("rst_mid_data", int'(OUT_DATA), 0);
      chk("rst_mid_busy", int'(BUSY), 0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_mid_quiet", int'(BUSY), 0);

      wq = '{0, 7, 10, 2};
      send_burst(); wait_done(-1);
      chk("post_c9", cap[9], 7); chk("post_c10", cap[10], 2); chk("post_err", cap_err, 0);

      repeat (2) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
